// File: rtl/wb_arb2_wdt.sv
// Two-master Wishbone arbiter with round-robin grant held for the whole cycle,
// plus a watchdog that aborts an unanswered strobe with a bus error.
//
// state | meaning
// IDLE  | no master owns the slave; s_* outputs held at 0
// GNT0  | master 0 owns the slave until m0_cyc_i drops
// GNT1  | master 1 owns the slave until m1_cyc_i drops
module wb_arb2_wdt #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  gnt_o,
    output logic        to_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam bit              WDT_EN  = (TIMEOUT != 0);

    state_t          state;
    logic            last;
    logic [TO_W-1:0] cnt;

    logic granted;
    logic sel1;
    logic cur_cyc;
    logic cur_stb;
    logic term;
    logic abort;

    always_comb begin
        granted = (state != IDLE);
        sel1    = (state == GNT1);
        cur_cyc = granted & (sel1 ? m1_cyc_i : m0_cyc_i);
        cur_stb = granted & (sel1 ? m1_stb_i : m0_stb_i);
        term    = s_ack_i | s_err_i | s_rty_i;
        // a slave termination in the same cycle always beats the watchdog
        abort   = WDT_EN & cur_cyc & cur_stb & ~term & (cnt == TO_LAST);
    end

    always_comb begin
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        s_we_o  = 1'b0;
        if (granted) begin
            s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
            s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
            s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
            s_we_o  = sel1 ? m1_we_i  : m0_we_i;
        end
        s_cyc_o  = cur_cyc & ~abort;
        s_stb_o  = cur_stb & ~abort;

        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        m0_ack_o = (state == GNT0) & s_ack_i;
        m0_err_o = (state == GNT0) & (s_err_i | abort);
        m0_rty_o = (state == GNT0) & s_rty_i;
        m1_ack_o = (state == GNT1) & s_ack_i;
        m1_err_o = (state == GNT1) & (s_err_i | abort);
        m1_rty_o = (state == GNT1) & s_rty_i;

        gnt_o    = {state == GNT1, state == GNT0};
        to_o     = abort;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            // a dropped cyc also covers the clear on every grant change
            if (!(cur_cyc && cur_stb) || term || abort) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + TO_W'(1);
            end

            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state <= last ? GNT0 : GNT1;
                    end else if (m0_cyc_i) begin
                        state <= GNT0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        last  <= 1'b0;
                        state <= m1_cyc_i ? GNT1 : IDLE;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        last  <= 1'b1;
                        state <= m0_cyc_i ? GNT0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arb2_wdt.sv
// Randomized two-master traffic against wb_arb2_wdt; a transaction-level
// scoreboard checks grants, terminations, watchdog aborts and the muxed slave path.
module tb_wb_arb2_wdt;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  gnt_o;
    logic        to_o;

    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];

    wb_arb2_wdt #(.TO_W(8), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .to_o(to_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  kind;   // 0 ack, 1 err, 2 rty
        logic        to;
        logic [31:0] rdata;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } exp_t;

    exp_t       eq0[$];
    exp_t       eq1[$];
    logic [1:0] gq[$];

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // master traffic generators
    int   mst   [2];
    int   gap   [2];
    int   beats [2];
    int   pause [2];
    logic term  [2];
    // reference arbitration and slave
    int   owner = -1;
    int   last  = 1;
    int   sc    = 0;
    int   lat   = 0;
    int   rk    = 0;
    logic [31:0] rdata;

    function automatic logic [2:0] kind_bits(input logic [1:0] k);
        return (k == 2'd0) ? 3'b100 : (k == 2'd1) ? 3'b010 : 3'b001;
    endfunction

    task automatic new_beat(input int m);
        adr[m] = $urandom;
        dat[m] = $urandom;
        sel[m] = 4'($urandom);
        we[m]  = 1'($urandom);
    endtask

    task automatic step(input bit allow_new);
        int   own_now;
        exp_t e;
        @(negedge clk_i);
        for (int m = 0; m < 2; m++) begin
            case (mst[m])
                0: begin
                    if (gap[m] > 0) gap[m]--;
                    else if (allow_new) begin
                        cyc[m] = 1'b1; stb[m] = 1'b1; new_beat(m);
                        beats[m] = $urandom_range(1, 4); mst[m] = 1;
                    end
                end
                1: begin
                    if (term[m]) begin
                        beats[m]--;
                        if (beats[m] == 0) begin
                            cyc[m] = 1'b0; stb[m] = 1'b0;
                            gap[m] = $urandom_range(0, 3); mst[m] = 0;
                        end else begin
                            pause[m] = $urandom_range(0, 2);
                            if (pause[m] == 0) new_beat(m);
                            else begin stb[m] = 1'b0; mst[m] = 2; end
                        end
                    end
                end
                default: begin
                    pause[m]--;
                    if (pause[m] == 0) begin stb[m] = 1'b1; new_beat(m); mst[m] = 1; end
                end
            endcase
        end

        // grant rules: requester wins alone, alternate on contention, hold while cyc
        own_now = owner;
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) owner = (last == 1) ? 0 : 1;
            else if (cyc[0])      owner = 0;
            else if (cyc[1])      owner = 1;
        end else if (!cyc[owner]) begin
            last  = owner;
            owner = cyc[1-owner] ? 1 - owner : -1;
        end
        gq.push_back(owner < 0 ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10));

        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        s_dat_i = $urandom;
        if (own_now >= 0 && cyc[own_now] && stb[own_now]) begin
            if (sc == 0) begin
                lat   = $urandom_range(0, 5);
                rk    = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
                rdata = $urandom;
                e.adr = adr[own_now]; e.dat = dat[own_now];
                e.sel = sel[own_now]; e.we = we[own_now];
                e.rdata = rdata;
                // slave answers on strobe cycle lat+1; watchdog fires on cycle TO
                if (lat + 1 <= TO) begin e.kind = 2'(rk); e.to = 1'b0; end
                else begin e.kind = 2'd1; e.to = 1'b1; end
                if (own_now == 0) eq0.push_back(e); else eq1.push_back(e);
            end
            sc++;
            if (sc == lat + 1) begin
                s_ack_i = (rk == 0); s_err_i = (rk == 1); s_rty_i = (rk == 2);
                s_dat_i = rdata;
            end
        end
        #3;
        term[0] = m0_ack_o | m0_err_o | m0_rty_o;
        term[1] = m1_ack_o | m1_err_o | m1_rty_o;
        if (own_now >= 0 && term[own_now]) sc = 0;
    endtask

    task automatic check_term(input int m, input logic [2:0] got, input logic [31:0] mdat);
        exp_t e;
        if ((m == 0 ? eq0.size() : eq1.size()) == 0) begin
            check($sformatf("m%0d unexpected termination", m), {61'd0, got}, 64'd0);
            return;
        end
        e = (m == 0) ? eq0.pop_front() : eq1.pop_front();
        check($sformatf("m%0d term kind", m), {61'd0, got}, {61'd0, kind_bits(e.kind)});
        check($sformatf("m%0d to_o", m), {63'd0, to_o}, {63'd0, e.to});
        check($sformatf("m%0d s_stb_o", m), {63'd0, s_stb_o}, {63'd0, ~e.to});
        check($sformatf("m%0d s_adr/we/sel", m), {27'd0, s_adr_o, s_we_o, s_sel_o},
              {27'd0, e.adr, e.we, e.sel});
        check($sformatf("m%0d s_dat_o", m), {32'd0, s_dat_o}, {32'd0, e.dat});
        if (!e.to) check($sformatf("m%0d dat_o", m), {32'd0, mdat}, {32'd0, e.rdata});
    endtask

    initial begin : monitor
        logic [1:0] g;
        forever begin
            @(negedge clk_i);
            #2;
            if (mon_en) begin
                if (gq.size() > 0) begin
                    g = gq.pop_front();
                    check("gnt_o", {62'd0, gnt_o}, {62'd0, g});
                end
                if (m0_ack_o | m0_err_o | m0_rty_o)
                    check_term(0, {m0_ack_o, m0_err_o, m0_rty_o}, m0_dat_o);
                if (m1_ack_o | m1_err_o | m1_rty_o)
                    check_term(1, {m1_ack_o, m1_err_o, m1_rty_o}, m1_dat_o);
                if (to_o) check("to_o with err", {63'd0, m0_err_o | m1_err_o}, 64'd1);
            end
        end
    end

    initial begin : main
        bit drained;
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
            adr[m] = '0; dat[m] = '0; sel[m] = '0;
            mst[m] = 0; gap[m] = 0; beats[m] = 0; pause[m] = 0; term[m] = 1'b0;
        end
        s_dat_i = 32'hdead_beef;
        rst_i = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1;
        s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check("reset gnt_o", {62'd0, gnt_o}, 64'd0);
        check("reset s_cyc/stb/we", {61'd0, s_cyc_o, s_stb_o, s_we_o}, 64'd0);
        check("reset s_adr_o", {32'd0, s_adr_o}, 64'd0);
        check("reset m0 terms", {61'd0, m0_ack_o, m0_err_o, m0_rty_o}, 64'd0);
        check("reset m1 terms", {61'd0, m1_ack_o, m1_err_o, m1_rty_o}, 64'd0);
        check("reset to_o", {63'd0, to_o}, 64'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        rst_i = 1'b0;
        #3;
        gq.push_back(2'b00);
        mon_en = 1'b1;

        for (int i = 0; i < 3000; i++) step(1'b1);

        drained = 1'b0;
        for (int i = 0; i < 300 && !drained; i++) begin
            step(1'b0);
            drained = (mst[0] == 0) && (mst[1] == 0);
        end
        step(1'b0);
        step(1'b0);
        #1;
        mon_en = 1'b0;
        check("traffic drained", {63'd0, drained}, 64'd1);
        check("m0 outstanding", 64'(eq0.size()), 64'd0);
        check("m1 outstanding", 64'(eq1.size()), 64'd0);
        gq.delete();

        // asynchronous reset while m1 owns the slave with an ack on the bus
        @(negedge clk_i);
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h0000_0010;
        for (int i = 0; i < 5 && gnt_o != 2'b10; i++) @(negedge clk_i);
        check("m1 granted before reset", {62'd0, gnt_o}, 64'd2);
        #1;
        s_ack_i = 1'b1;
        #1;
        check("m1 ack before reset", {63'd0, m1_ack_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        check("async reset s_cyc_o", {63'd0, s_cyc_o}, 64'd0);
        check("async reset gnt_o", {62'd0, gnt_o}, 64'd0);
        check("async reset m1 terms", {61'd0, m1_ack_o, m1_err_o, m1_rty_o}, 64'd0);
        check("async reset m0 terms", {61'd0, m0_ack_o, m0_err_o, m0_rty_o}, 64'd0);
        @(negedge clk_i);
        s_ack_i = 1'b0;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("first grant after reset", {62'd0, gnt_o}, 64'd1);
        check("s_adr_o follows m0", {32'd0, s_adr_o}, {32'd0, adr[0]});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
